// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential HI/LO multiply/divide unit for the MIPS core.
// Iterative shift-add multiplier and restoring divider, both working on
// operand magnitudes with the sign fixed up in a final cycle.
// Owns the HI/LO registers; the pipeline reads hi/lo directly.
//
// Build option: define MULT_DIV_FAST_MUL_EN to compute MULT/MULTU with a
// single-cycle multiplier (IDLE -> FIX directly). DIV/DIVU are unaffected.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a new op; MTHI/MTLO/reserved complete here
// S_MUL  | shift-add multiply, one product bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_FIX  | sign correction and HI/LO write, done pulse follows
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   // Multiply: opb_q = multiplicand, acc_q = {partial product, multiplier}.
   // Divide:   opb_q = divisor,      acc_q = {remainder, dividend/quotient}.
   logic [WIDTH-1:0]     opb_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic                 neg_q;        // product or quotient is negative
   logic                 rem_neg_q;    // remainder is negative
   logic                 mul_q;        // op in flight is a multiply
   logic                 dbz_q;        // op in flight divides by zero
   logic [WIDTH-1:0]     rs_raw_q;     // raw dividend, returned in HI on divide by zero
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic                 done_q;
   logic                 dbz_flag_q;

   logic                 accept;
   logic                 is_mul_op, is_div_op, op_signed;
   logic [WIDTH-1:0]     mag_rs, mag_rt;
   logic                 last_iter;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift, div_diff;
   logic [2*WIDTH-1:0]   mul_res;
   logic [WIDTH-1:0]     res_hi, res_lo;

   assign op_ready    = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_flag_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

   // Operand decode and magnitude conversion for signed ops.
   always_comb begin
      accept    = op_valid && op_ready;
      is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
      is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      mag_rs    = (op_signed && rs[WIDTH-1]) ? (~rs + 1'b1) : rs;
      mag_rt    = (op_signed && rt[WIDTH-1]) ? (~rt + 1'b1) : rt;
   end

   // One iteration of shift-add multiply and restoring divide.
   always_comb begin
      last_iter = (cnt_q == CNT_W'(WIDTH - 1));
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_q};
   end

   // Final sign correction; divide by zero overrides the quotient path.
   always_comb begin
      mul_res = neg_q ? (~acc_q + 1'b1) : acc_q;
      res_hi  = '0;
      res_lo  = '0;
      if (mul_q) begin
         res_hi = mul_res[2*WIDTH-1:WIDTH];
         res_lo = mul_res[WIDTH-1:0];
      end else if (dbz_q) begin
         res_hi = rs_raw_q;
         res_lo = '1;
      end else begin
         res_lo = neg_q     ? (~acc_q[WIDTH-1:0] + 1'b1)       : acc_q[WIDTH-1:0];
         res_hi = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_mul_op) begin
`ifdef MULT_DIV_FAST_MUL_EN
                  state_d = S_FIX;
`else
                  state_d = S_MUL;
`endif
               end else if (is_div_op) begin
                  state_d = S_DIV;
               end
            end
         end
         S_MUL:   if (last_iter) state_d = S_FIX;
         S_DIV:   if (last_iter) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: operand latch on accept, iterations, HI/LO write and flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         opb_q      <= '0;
         acc_q      <= '0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         mul_q      <= 1'b0;
         dbz_q      <= 1'b0;
         rs_raw_q   <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         dbz_flag_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  dbz_flag_q <= 1'b0;
                  cnt_q      <= '0;
                  mul_q      <= is_mul_op;
                  dbz_q      <= (rt == '0);
                  rs_raw_q   <= rs;
                  if (is_mul_op) begin
                     neg_q     <= op_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                     rem_neg_q <= 1'b0;
                     opb_q     <= mag_rs;
`ifdef MULT_DIV_FAST_MUL_EN
                     acc_q     <= {{WIDTH{1'b0}}, mag_rs} * {{WIDTH{1'b0}}, mag_rt};
`else
                     acc_q     <= {{WIDTH{1'b0}}, mag_rt};
`endif
                  end else if (is_div_op) begin
                     neg_q     <= op_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                     rem_neg_q <= op_signed & rs[WIDTH-1];
                     opb_q     <= mag_rt;
                     acc_q     <= {{WIDTH{1'b0}}, mag_rs};
                  end else if (op == OP_MTHI) begin
                     hi_q <= rs;
                  end else if (op == OP_MTLO) begin
                     lo_q <= rs;
                  end
               end
            end
            S_MUL: begin
               acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
               cnt_q <= cnt_q + 1'b1;
            end
            S_DIV: begin
               if (!div_diff[WIDTH])
                  acc_q <= {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_q <= {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               cnt_q <= cnt_q + 1'b1;
            end
            S_FIX: begin
               hi_q   <= res_hi;
               lo_q   <= res_lo;
               done_q <= 1'b1;
               if (!mul_q && dbz_q) dbz_flag_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed test-plan cases with literal
// expectations plus randomized traffic, all compared every cycle against
// an arithmetic reference model of HI/LO, busy, done and div_by_zero.
module tb_mult_div_unit;

   localparam int W = 32;
`ifdef MULT_DIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          op_valid = 1'b0;
   logic          op_ready;
   logic [2:0]    op = 3'd0;
   logic [W-1:0]  rs = '0;
   logic [W-1:0]  rt = '0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int checks = 0;
   int fails  = 0;

   mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
      .op(op), .rs(rs), .rt(rt), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
   bit           m_dbz = 0, r_dbz = 0, m_done = 0;
   int           m_cnt = 0;

   function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output bit z);
      longint      sa, sb, sp;
      logic [63:0] up;
      sa = $signed(a);
      sb = $signed(b);
      z = 0; h = '0; l = '0;
      case (o)
         3'd0: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
         3'd1: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
         3'd2: begin
            if (b == 0) begin l = '1; h = a; z = 1; end
            else begin sp = sa / sb; l = sp[31:0]; sp = sa % sb; h = sp[31:0]; end
         end
         3'd3: begin
            if (b == 0) begin l = '1; h = a; z = 1; end
            else begin l = a / b; h = a % b; end
         end
         default: ;
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_hi = '0; m_lo = '0; m_dbz = 0; m_done = 0; m_cnt = 0;
      end else begin
         m_done = 0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_hi = r_hi; m_lo = r_lo; m_done = 1;
               if (r_dbz) m_dbz = 1;
            end
         end else if (op_valid) begin
            m_dbz = 0;
            case (op)
               3'd0, 3'd1: begin ref_op(op, rs, rt, r_hi, r_lo, r_dbz); m_cnt = MUL_LAT; end
               3'd2, 3'd3: begin ref_op(op, rs, rt, r_hi, r_lo, r_dbz); m_cnt = DIV_LAT; end
               3'd4: m_hi = rs;
               3'd5: m_lo = rs;
               default: ;
            endcase
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (reset_n) begin
         check("busy",        {63'b0, busy},        {63'b0, m_cnt > 0});
         check("op_ready",    {63'b0, op_ready},    {63'b0, m_cnt == 0});
         check("done",        {63'b0, done},        {63'b0, m_done});
         check("div_by_zero", {63'b0, div_by_zero}, {63'b0, m_dbz});
         check("hi",          {32'b0, hi},          {32'b0, m_hi});
         check("lo",          {32'b0, lo},          {32'b0, m_lo});
      end
   end

   // ---------------- stimulus helpers (called at a falling edge) ----------------
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      while (op_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (op_ready !== 1'b1) begin
         checks++; fails++;
         $display("FAIL issue_timeout: op_ready=%0b required=1", op_ready);
      end
      op_valid = 1'b1; op = o; rs = a; rt = b;
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic wait_done(output int bc);
      int n;
      bc = 0; n = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checks++; fails++;
         $display("FAIL done_timeout: done=%0b required=1 after %0d cycles", done, n);
      end
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom % 8)
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return W'($urandom % 16);
         4: return -W'($urandom % 16);
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int  bc;
      bit  saw_done;

      repeat (3) @(negedge clk);
      check("rst_hi",   {32'b0, hi}, 64'h0);
      check("rst_lo",   {32'b0, lo}, 64'h0);
      check("rst_busy", {63'b0, busy}, 64'h0);
      check("rst_done", {63'b0, done}, 64'h0);
      check("rst_dbz",  {63'b0, div_by_zero}, 64'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // MULTU all-ones squared
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(bc);
      check("multu_hi",   {32'b0, hi}, 64'hFFFF_FFFE);
      check("multu_lo",   {32'b0, lo}, 64'h0000_0001);
      check("model_multu_hi", {32'b0, m_hi}, 64'hFFFF_FFFE);
      check("multu_busy_cycles", 64'(bc), 64'(MUL_LAT));
      @(negedge clk);
      check("multu_done_once", {63'b0, done}, 64'h0);

      // MULT -2 * 3
      issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
      wait_done(bc);
      check("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
      check("mult_lo", {32'b0, lo}, 64'hFFFF_FFFA);
      check("model_mult_lo", {32'b0, m_lo}, 64'hFFFF_FFFA);

      // DIV -7 / 2
      issue(3'd2, 32'hFFFF_FFF9, 32'h2);
      wait_done(bc);
      check("div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
      check("div_hi", {32'b0, hi}, 64'hFFFF_FFFF);
      check("div_busy_cycles", 64'(bc), 64'(DIV_LAT));

      // DIVU 7 / 2
      issue(3'd3, 32'h7, 32'h2);
      wait_done(bc);
      check("divu_lo", {32'b0, lo}, 64'h3);
      check("divu_hi", {32'b0, hi}, 64'h1);

      // DIVU by zero, then MTLO clears the flag
      issue(3'd3, 32'h1234, 32'h0);
      wait_done(bc);
      check("dbz_lo",   {32'b0, lo}, 64'hFFFF_FFFF);
      check("dbz_hi",   {32'b0, hi}, 64'h1234);
      check("dbz_flag", {63'b0, div_by_zero}, 64'h1);
      check("dbz_latency", 64'(bc), 64'(DIV_LAT));
      @(negedge clk);
      check("dbz_sticky", {63'b0, div_by_zero}, 64'h1);
      issue(3'd5, 32'h55, 32'h0);
      check("mtlo_clears_dbz", {63'b0, div_by_zero}, 64'h0);
      check("mtlo_lo", {32'b0, lo}, 64'h55);

      // DIV signed overflow
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(bc);
      check("ovf_lo", {32'b0, lo}, 64'h8000_0000);
      check("ovf_hi", {32'b0, hi}, 64'h0);

      // MTHI
      issue(3'd4, 32'hA5A5_A5A5, 32'h0);
      check("mthi_hi",   {32'b0, hi}, 64'hA5A5_A5A5);
      check("mthi_busy", {63'b0, busy}, 64'h0);
      check("mthi_done", {63'b0, done}, 64'h0);

      // MTLO requested during a DIV is ignored
      issue(3'd3, 32'd100, 32'd7);
      op_valid = 1'b1; op = 3'd5; rs = 32'hDEAD_BEEF; rt = '0;
      repeat (5) begin
         check("hold_op_ready", {63'b0, op_ready}, 64'h0);
         check("hold_lo", {32'b0, lo}, 64'h8000_0000);
         @(negedge clk);
      end
      op_valid = 1'b0;
      wait_done(bc);
      check("divu100_lo", {32'b0, lo}, 64'd14);
      check("divu100_hi", {32'b0, hi}, 64'd2);

      // MULT with a zero operand
      issue(3'd0, 32'h0, 32'h0001_2345);
      wait_done(bc);
      check("mult0_hi", {32'b0, hi}, 64'h0);
      check("mult0_lo", {32'b0, lo}, 64'h0);
      check("mult0_latency", 64'(bc), 64'(MUL_LAT));

      // Reset in the middle of MULTU 3*5
      issue(3'd1, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_hi",   {32'b0, hi}, 64'h0);
      check("abort_lo",   {32'b0, lo}, 64'h0);
      check("abort_busy", {63'b0, busy}, 64'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      saw_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1;
      end
      check("abort_no_done", {63'b0, saw_done}, 64'h0);

      // Randomized traffic; op_valid also toggles while busy
      repeat (3000) begin
         op_valid = ($urandom % 4) != 0;
         op       = 3'($urandom % 8);
         rs       = rand_operand();
         rt       = rand_operand();
         @(negedge clk);
      end
      op_valid = 1'b0;
      repeat (40) @(negedge clk);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
